uart_result_tx: RTL and testbench
=================================

Name: uart_result_tx

Overview:
Transmit path from FPGA back to PC. It buffers result bytes (Sharpe compare flags and ratio bytes) in a small FIFO and serializes them as 8N1 UART frames on the GoBoard USB-UART TX pin. It mirrors the receive-side FIFO buffer and closes the PC<->FPGA loop. The upstream compare logic writes bytes; this block drains them at line rate.

Parameters:
CLKS_PER_BIT, 217, clock cycles per UART bit (25 MHz / 115200); minimum legal value 2
FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2
DATA_W, 8, payload bits per frame; fixed at 8 for this revision

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
wr_en  input  1  push din into FIFO on rising clk edge
din  input  8  byte to transmit
full  output  1  FIFO holds FIFO_DEPTH entries; writes ignored
empty  output  1  FIFO holds 0 entries
overflow  output  1  one-cycle pulse when wr_en is asserted while full
tx_busy  output  1  high in any state other than IDLE
tx_serial  output  1  UART line; idle high

Behaviour:
- Reset (async, takes effect immediately): FIFO count=0, pointers=0, FSM=IDLE, tx_serial=1, tx_busy=0, full=0, empty=1, overflow=0. Reset mid-frame aborts the frame, and the line returns high at once.
- FIFO: registered count, rd_ptr, and wr_ptr. Pointers wrap modulo FIFO_DEPTH. empty = (count==0). full = (count==FIFO_DEPTH). Both flags derive from the registered count.
- Write while not full: store din at wr_ptr and increment count. Write while full: data is dropped, the FIFO is unchanged, and overflow pulses for 1 cycle.
- Pop is internal only. It occurs in IDLE when !empty.
- Simultaneous push and pop with count in 1..DEPTH-1: count unchanged, both pointers advance.
- Simultaneous push and pop when full: the pop frees a slot, so the push is accepted. No overflow; count stays DEPTH.
- Push while empty: the FSM cannot pop the same cycle because it sees empty=1. Transmit starts on the following cycle.
- FSM states:
  - IDLE: tx_serial=1. If !empty, pop the head into shift register sh[7:0], load bit counter=0, go to START.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_serial=sh[bit_idx], sent LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: 0..CLKS_PER_BIT-1, cleared on every state or bit change, width $clog2(CLKS_PER_BIT).
- tx_serial is driven from a register, so it is glitch-free.
- Latency: wr_en at edge N into an empty FIFO gives empty=0 after N, then pop and tx_serial=0 after edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back bytes: STOP -> IDLE (1 cycle, line high) -> START. The inter-frame gap is 10*CLKS_PER_BIT+1 cycles start-to-start.
- tx_busy=1 from the pop edge through the last STOP cycle.
- wr_en is not gated by tx_busy. Writes during transmission are buffered.

Test Plan:
1. CLKS_PER_BIT=4, write 0xA5 once -> tx_serial low 1 cycle after empty falls. Line sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1 (start, 0xA5 LSB first, stop). tx_busy high for 40 cycles.
2. Assert rst async mid-DATA (bit 3 of 0x3C) -> tx_serial=1 and tx_busy=0 without waiting for a clk edge. FIFO empty. Nothing transmits after rst is released.
3. Write 9 bytes 0x01..0x09 on consecutive cycles with DEPTH=8 and a line idle at start:
   - first byte is popped at cycle 2, so all 9 are accepted;
   - full=1 after the 9th write;
   - a 10th write (0xFF) while full pulses overflow for 1 cycle and is never transmitted.
4. Continuous stream of 3 bytes 0x00, 0xFF, 0x55 -> frames start exactly 41 cycles apart. Decoded bytes arrive in order: 0x00, 0xFF, 0x55.
5. Fill the FIFO to full, then assert wr_en (din=0x77) on the IDLE pop edge -> write accepted, overflow stays 0, count stays 8, and 0x77 is transmitted last.
6. Idle with no writes for 100 cycles after reset -> tx_serial constant 1, empty=1, tx_busy=0.

Source files
------------

// File: rtl/uart_result_tx.sv
// Result-byte transmitter: a small FIFO drained by an 8N1 UART serializer.
// Upstream logic pushes bytes at will; the serializer pops one whenever the line is idle.
module uart_result_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 8,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              tx_busy,
    output logic              tx_serial
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] sh;

    logic pop;
    logic push;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // A pop in the same cycle frees a slot, so a write while full is still accepted.
    assign pop  = (state == IDLE) && !empty;
    assign push = wr_en && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full && !pop;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
        if (pop)  sh <= mem[rd_ptr];
    end

    // Line driver: every output is a flop, so tx_serial cannot glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    baud_cnt  <= '0;
                    if (!empty) begin
                        state     <= START;
                        tx_serial <= 1'b0;
                        tx_busy   <= 1'b1;
                        bit_idx   <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt  <= '0;
                        state     <= DATA;
                        tx_serial <= sh[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state     <= STOP;
                            tx_serial <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx_serial <= sh[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        tx_busy  <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_result_tx.sv
// Directed bench for uart_result_tx with a short bit period and a free-running line decoder.
module tb_uart_result_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] din;
    logic       full, empty, overflow, tx_busy, tx_serial;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [8:0] rx_q[$];
    int         rx_t[$];

    int         mon_st;
    logic [7:0] mon_b;
    logic       mon_ok;
    logic       mon_stp;

    uart_result_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (8),
        .DATA_W      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .din      (din),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .tx_busy  (tx_busy),
        .tx_serial(tx_serial)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: k counts negedges from the start-bit sample; data bit i is sampled mid-bit.
    always begin
        @(negedge clk);
        if (rst === 1'b0 && tx_serial === 1'b0) begin
            mon_st  = cyc;
            mon_ok  = 1'b1;
            mon_b   = '0;
            mon_stp = 1'b0;
            for (int k = 1; k <= 38; k++) begin
                @(negedge clk);
                if (rst !== 1'b0) mon_ok = 1'b0;
                if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) mon_b[(k - 6) / 4] = tx_serial;
                if (k == 38) mon_stp = tx_serial;
            end
            if (mon_ok) begin
                rx_q.push_back({mon_stp, mon_b});
                rx_t.push_back(mon_st);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_en = 1'b1;
        din   = d;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] line_v;
        logic [8:0] got;
        int         n_low, n_busy, n_nempty, waited;
        bit         seen;

        rst   = 1'b1;
        wr_en = 1'b0;
        din   = 8'h00;

        // reset state, before any clock edge
        #2;
        check("rst_tx_serial", 32'(tx_serial), 32'd1);
        check("rst_tx_busy",   32'(tx_busy),   32'd0);
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_full",      32'(full),      32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // idle line for 100 cycles
        n_low = 0; n_busy = 0; n_nempty = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_serial !== 1'b1) n_low++;
            if (tx_busy !== 1'b0) n_busy++;
            if (empty !== 1'b1) n_nempty++;
        end
        check("idle_line_low_cycles", 32'(n_low),    32'd0);
        check("idle_busy_cycles",     32'(n_busy),   32'd0);
        check("idle_nonempty_cycles", 32'(n_nempty), 32'd0);
        check("idle_no_frames",       32'(rx_q.size()), 32'd0);

        // single byte 0xA5: latency and exact line waveform
        push_byte(8'hA5);
        check("a5_empty_after_write", 32'(empty),     32'd0);
        check("a5_line_before_pop",   32'(tx_serial), 32'd1);
        check("a5_busy_before_pop",   32'(tx_busy),   32'd0);
        line_v = {1'b1, 8'hA5, 1'b0};
        n_busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check($sformatf("a5_line_k%0d", k), 32'(tx_serial), 32'(line_v[k / 4]));
            if (tx_busy === 1'b1) n_busy++;
        end
        check("a5_busy_cycles", 32'(n_busy), 32'd40);
        @(negedge clk);
        check("a5_busy_after_frame", 32'(tx_busy),   32'd0);
        check("a5_line_after_frame", 32'(tx_serial), 32'd1);
        check("a5_empty_after_frame", 32'(empty),    32'd1);
        check("a5_decoded_count", 32'(rx_q.size()), 32'd1);
        got = (rx_q.size() > 0) ? rx_q[0] : 9'h000;
        check("a5_decoded_byte", 32'(got), 32'h1A5);
        rx_q.delete();
        rx_t.delete();

        // back-to-back stream 0x00, 0xFF, 0x55
        repeat (5) @(negedge clk);
        wr_en = 1'b1; din = 8'h00;
        @(posedge clk); @(negedge clk); din = 8'hFF;
        @(posedge clk); @(negedge clk); din = 8'h55;
        @(posedge clk); @(negedge clk); wr_en = 1'b0;
        waited = 0;
        while (rx_q.size() < 3 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("stream_frame_count", 32'(rx_q.size()), 32'd3);
        check("stream_byte0", 32'((rx_q.size() > 0) ? rx_q[0] : 9'h000), 32'h100);
        check("stream_byte1", 32'((rx_q.size() > 1) ? rx_q[1] : 9'h000), 32'h1FF);
        check("stream_byte2", 32'((rx_q.size() > 2) ? rx_q[2] : 9'h000), 32'h155);
        check("stream_gap01", 32'((rx_t.size() > 1) ? rx_t[1] - rx_t[0] : 0), 32'd41);
        check("stream_gap12", 32'((rx_t.size() > 2) ? rx_t[2] - rx_t[1] : 0), 32'd41);
        repeat (5) @(negedge clk);
        check("stream_empty_after", 32'(empty), 32'd1);
        rx_q.delete();
        rx_t.delete();

        // 9 writes into depth 8, overflow on a 10th, then push on the pop edge while full
        repeat (5) @(negedge clk);
        wr_en = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            din = 8'(i);
            @(posedge clk);
            @(negedge clk);
            if (i == 1) begin
                check("fill_busy_after_w1",  32'(tx_busy), 32'd0);
                check("fill_empty_after_w1", 32'(empty),   32'd0);
            end
            if (i == 2) check("fill_busy_after_w2", 32'(tx_busy), 32'd1);
            if (i == 8) check("fill_not_full_w8", 32'(full), 32'd0);
        end
        check("fill_full_after_w9",     32'(full),     32'd1);
        check("fill_overflow_after_w9", 32'(overflow), 32'd0);
        din = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        check("ovf_pulse",     32'(overflow), 32'd1);
        check("ovf_full_kept", 32'(full),     32'd1);
        @(negedge clk);
        check("ovf_pulse_end", 32'(overflow), 32'd0);

        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 100) begin
            if (tx_busy === 1'b0 && full === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        check("popedge_reached", 32'(seen), 32'd1);
        wr_en = 1'b1;
        din   = 8'h77;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        check("popedge_overflow", 32'(overflow), 32'd0);
        check("popedge_full",     32'(full),     32'd1);
        check("popedge_busy",     32'(tx_busy),  32'd1);

        waited = 0;
        while (rx_q.size() < 10 && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        repeat (60) @(negedge clk);
        check("fill_frame_count", 32'(rx_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            got = (rx_q.size() > i) ? rx_q[i] : 9'h000;
            check($sformatf("fill_byte%0d", i), 32'(got),
                  (i < 9) ? 32'(9'h100 | 9'(i + 1)) : 32'h177);
        end
        check("fill_empty_after", 32'(empty), 32'd1);
        rx_q.delete();
        rx_t.delete();

        // async reset during the start bit: line must rise without a clock edge
        push_byte(8'h3C);
        @(negedge clk);
        check("rst_start_line_low", 32'(tx_serial), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("rst_start_line", 32'(tx_serial), 32'd1);
        check("rst_start_busy", 32'(tx_busy),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (45) @(negedge clk);

        // async reset in data bit 3 of 0x3C
        push_byte(8'h3C);
        @(negedge clk);
        repeat (17) @(negedge clk);
        check("rst_data_busy_before", 32'(tx_busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_data_line",  32'(tx_serial), 32'd1);
        check("rst_data_busy",  32'(tx_busy),   32'd0);
        check("rst_data_empty", 32'(empty),     32'd1);
        check("rst_data_full",  32'(full),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_low = 0; n_busy = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_serial !== 1'b1) n_low++;
            if (tx_busy !== 1'b0) n_busy++;
        end
        check("post_rst_line_low_cycles", 32'(n_low),  32'd0);
        check("post_rst_busy_cycles",     32'(n_busy), 32'd0);
        check("post_rst_no_frames",       32'(rx_q.size()), 32'd0);
        check("post_rst_empty",           32'(empty),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
